// File: rtl/clknrst_mon.sv
// clknrst_mon: passive monitor for a generated clock/reset pair.
// The generated clock and both reset polarities are oversampled on clk. The
// block measures the mon_clk period and the mon_reset pulse length, and flags
// period violations, clock stalls, short resets and polarity mismatches.
//
// Ports:
//   clk, reset           monitor clock, asynchronous active-high reset
//   mon_clk              generated clock, asynchronous, sampled as data
//   mon_reset            generated active-high reset, sampled
//   mon_reset_n          generated active-low reset, sampled
//   clear                synchronous clear of the sticky error flags
//   period/period_valid  last measured mon_clk period (clk cycles) + pulse
//   rst_len/rst_len_valid last measured mon_reset high length + pulse
//   clk_stall            level, mon_clk has stopped toggling
//   period_err           sticky, a period fell outside [MIN_PER, MAX_PER]
//   short_rst_err        sticky, a reset pulse was shorter than MIN_RST
//   pol_err              sticky, mon_reset == mon_reset_n for too long
module clknrst_mon #(
  parameter int CNT_W        = 16,
  parameter int MIN_PER      = 4,
  parameter int MAX_PER      = 64,
  parameter int STALL_CYC    = 256,
  parameter int MIN_RST      = 8,
  parameter int MISMATCH_TOL = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mon_clk,
  input  logic             mon_reset,
  input  logic             mon_reset_n,
  input  logic             clear,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic [CNT_W-1:0] rst_len,
  output logic             rst_len_valid,
  output logic             clk_stall,
  output logic             period_err,
  output logic             short_rst_err,
  output logic             pol_err
);

  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_PER_C = CNT_W'(MIN_PER);
  localparam logic [CNT_W-1:0] MAX_PER_C = CNT_W'(MAX_PER);
  localparam logic [CNT_W-1:0] STALL_C   = CNT_W'(STALL_CYC);
  localparam logic [CNT_W-1:0] MIN_RST_C = CNT_W'(MIN_RST);
  localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(MISMATCH_TOL);

  typedef enum logic [1:0] {IDLE, ARMED, STALLED} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + ONE_C;
  endfunction

  // Synchronizer chains: stage 3 is the registered copy for edge detection.
  logic [2:0] mclk_q, mrst_q, mrstn_q;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic             pv_q, pv_d;
  logic             stall_q, stall_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [CNT_W-1:0] rlen_q, rlen_d;
  logic             rv_q, rv_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;
  logic             perr_q, perr_d;
  logic             serr_q, serr_d;
  logic             polerr_q, polerr_d;

  logic mclk_rise, mrst_rise, mrst_fall;
  logic perr_set, serr_set, polerr_set;

  assign mclk_rise = mclk_q[1] & ~mclk_q[2];
  assign mrst_rise = mrst_q[1] & ~mrst_q[2];
  assign mrst_fall = ~mrst_q[1] & mrst_q[2];

  // Clock period / stall FSM
  always_comb begin
    state_d  = state_q;
    cnt_d    = sat_inc(cnt_q);
    per_d    = per_q;
    pv_d     = 1'b0;
    perr_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (mclk_rise) begin
          state_d = ARMED;
          cnt_d   = ONE_C;
        end else if (cnt_q == STALL_C) begin
          state_d = STALLED;
        end
      end
      ARMED: begin
        if (mclk_rise) begin
          per_d    = cnt_q;
          pv_d     = 1'b1;
          perr_set = (cnt_q < MIN_PER_C) || (cnt_q > MAX_PER_C);
          cnt_d    = ONE_C;
        end else if (cnt_q == STALL_C) begin
          state_d = STALLED;
        end
      end
      STALLED: begin
        // The interval spanning a stall is not a valid measurement.
        if (mclk_rise) begin
          state_d = ARMED;
          cnt_d   = ONE_C;
        end
      end
      default: state_d = IDLE;
    endcase
    stall_d = (state_d == STALLED);
  end

  // Reset length and polarity checks
  always_comb begin
    rlen_d   = rlen_q;
    rv_d     = 1'b0;
    serr_set = 1'b0;
    rcnt_d   = rcnt_q;
    // The rising-edge cycle is itself the first high cycle, hence load 1.
    if (mrst_rise) begin
      rcnt_d = ONE_C;
    end else if (mrst_q[1]) begin
      rcnt_d = sat_inc(rcnt_q);
    end
    if (mrst_fall) begin
      rlen_d   = rcnt_q;
      rv_d     = 1'b1;
      serr_set = (rcnt_q < MIN_RST_C);
    end
    mcnt_d     = (mrst_q[1] == mrstn_q[1]) ? sat_inc(mcnt_q) : '0;
    polerr_set = (mcnt_d > TOL_C);
  end

  // Sticky flags: a set in the same cycle as clear wins.
  always_comb begin
    perr_d   = perr_set   | (perr_q   & ~clear);
    serr_d   = serr_set   | (serr_q   & ~clear);
    polerr_d = polerr_set | (polerr_q & ~clear);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mclk_q   <= '0;
      mrst_q   <= '0;
      mrstn_q  <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      per_q    <= '0;
      pv_q     <= 1'b0;
      stall_q  <= 1'b0;
      rcnt_q   <= '0;
      rlen_q   <= '0;
      rv_q     <= 1'b0;
      mcnt_q   <= '0;
      perr_q   <= 1'b0;
      serr_q   <= 1'b0;
      polerr_q <= 1'b0;
    end else begin
      mclk_q   <= {mclk_q[1:0], mon_clk};
      mrst_q   <= {mrst_q[1:0], mon_reset};
      mrstn_q  <= {mrstn_q[1:0], mon_reset_n};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      pv_q     <= pv_d;
      stall_q  <= stall_d;
      rcnt_q   <= rcnt_d;
      rlen_q   <= rlen_d;
      rv_q     <= rv_d;
      mcnt_q   <= mcnt_d;
      perr_q   <= perr_d;
      serr_q   <= serr_d;
      polerr_q <= polerr_d;
    end
  end

  assign period        = per_q;
  assign period_valid  = pv_q;
  assign rst_len       = rlen_q;
  assign rst_len_valid = rv_q;
  assign clk_stall     = stall_q;
  assign period_err    = perr_q;
  assign short_rst_err = serr_q;
  assign pol_err       = polerr_q;

endmodule

// File: tb/tb_clknrst_mon.sv
// Directed bench for clknrst_mon. Inputs change 1 time unit after the rising
// clk edge; outputs are sampled at the same point, after registers settle.
module tb_clknrst_mon;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             mon_clk;
  logic             mon_reset;
  logic             mon_reset_n;
  logic             clear;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic [CNT_W-1:0] rst_len;
  logic             rst_len_valid;
  logic             clk_stall;
  logic             period_err;
  logic             short_rst_err;
  logic             pol_err;

  clknrst_mon #(
    .CNT_W(CNT_W), .MIN_PER(4), .MAX_PER(64), .STALL_CYC(256),
    .MIN_RST(8), .MISMATCH_TOL(2)
  ) dut (
    .clk(clk), .reset(reset), .mon_clk(mon_clk), .mon_reset(mon_reset),
    .mon_reset_n(mon_reset_n), .clear(clear), .period(period),
    .period_valid(period_valid), .rst_len(rst_len),
    .rst_len_valid(rst_len_valid), .clk_stall(clk_stall),
    .period_err(period_err), .short_rst_err(short_rst_err), .pol_err(pol_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Observation record, updated once per cycle.
  int cyc = 0;
  int pv_cnt = 0, pv_cyc = 0, pv_prev = 0, last_per = 0;
  int rv_cnt = 0, last_rlen = 0;
  int stall_rise = 0;
  logic stall_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (period_valid) begin
      pv_cnt++;
      pv_prev  = pv_cyc;
      pv_cyc   = cyc;
      last_per = int'(period);
    end
    if (rst_len_valid) begin
      rv_cnt++;
      last_rlen = int'(rst_len);
    end
    if (clk_stall && !stall_prev) stall_rise = cyc;
    stall_prev = clk_stall;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive_clk(input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      mon_clk = 1'b1;
      ticks(hi);
      mon_clk = 1'b0;
      ticks(lo);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_period"},        32'(period),        0);
    check_eq({pfx, "_period_valid"},  32'(period_valid),  0);
    check_eq({pfx, "_rst_len"},       32'(rst_len),       0);
    check_eq({pfx, "_rst_len_valid"}, 32'(rst_len_valid), 0);
    check_eq({pfx, "_clk_stall"},     32'(clk_stall),     0);
    check_eq({pfx, "_period_err"},    32'(period_err),    0);
    check_eq({pfx, "_short_rst_err"}, 32'(short_rst_err), 0);
    check_eq({pfx, "_pol_err"},       32'(pol_err),       0);
  endtask

  initial begin
    reset       = 1'b1;
    mon_clk     = 1'b0;
    mon_reset   = 1'b0;
    mon_reset_n = 1'b1;
    clear       = 1'b0;
    ticks(3);
    check_all_zero("rst");

    // Nominal period of 10 (5 high / 5 low).
    reset = 1'b0;
    tick();
    drive_clk(5, 5, 1);
    check_eq("p10_no_first_valid", 32'(pv_cnt), 0);
    drive_clk(5, 5, 4);
    check_eq("p10_valid_count", 32'(pv_cnt), 4);
    check_eq("p10_period", 32'(last_per), 10);
    check_eq("p10_spacing", 32'(pv_cyc - pv_prev), 10);
    check_eq("p10_period_err", 32'(period_err), 0);
    check_eq("p10_stall", 32'(clk_stall), 0);
    check_eq("p10_pol_err", 32'(pol_err), 0);

    // Short period of 3, sticky flag, clear, re-set.
    pv_cnt = 0;
    drive_clk(2, 1, 2);
    ticks(3);
    check_eq("p3_valid_count", 32'(pv_cnt), 2);
    check_eq("p3_period", 32'(last_per), 3);
    check_eq("p3_err_set", 32'(period_err), 1);
    ticks(2);
    check_eq("p3_err_sticky", 32'(period_err), 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_eq("p3_err_cleared", 32'(period_err), 0);
    check_eq("p3_clear_keeps_period", 32'(period), 3);
    drive_clk(2, 1, 2);
    ticks(3);
    check_eq("p3_err_reset_again", 32'(period_err), 1);

    // Stall: hold mon_clk low after the last measured edge.
    pv_cnt = 0;
    stall_rise = 0;
    ticks(300);
    check_eq("stall_level", 32'(clk_stall), 1);
    check_eq("stall_delay", 32'(stall_rise - pv_cyc), 256);
    check_eq("stall_no_valid", 32'(pv_cnt), 0);
    drive_clk(5, 5, 1);
    check_eq("resume_stall_clear", 32'(clk_stall), 0);
    check_eq("resume_first_no_valid", 32'(pv_cnt), 0);
    drive_clk(5, 5, 2);
    check_eq("resume_valid_count", 32'(pv_cnt), 2);
    check_eq("resume_period", 32'(last_per), 10);

    // Reset pulse lengths with complementary polarity.
    mon_reset = 1'b1; mon_reset_n = 1'b0;
    ticks(5);
    mon_reset = 1'b0; mon_reset_n = 1'b1;
    ticks(4);
    check_eq("rst5_valid_count", 32'(rv_cnt), 1);
    check_eq("rst5_len", 32'(last_rlen), 5);
    check_eq("rst5_short_err", 32'(short_rst_err), 1);
    check_eq("rst5_pol_err", 32'(pol_err), 0);
    mon_reset = 1'b1; mon_reset_n = 1'b0;
    ticks(20);
    mon_reset = 1'b0; mon_reset_n = 1'b1;
    ticks(4);
    check_eq("rst20_valid_count", 32'(rv_cnt), 2);
    check_eq("rst20_len", 32'(rst_len), 20);
    check_eq("rst20_short_err_sticky", 32'(short_rst_err), 1);

    // Polarity mismatch: 2 cycles tolerated, 3 cycles flagged.
    mon_reset_n = 1'b0;
    ticks(2);
    mon_reset_n = 1'b1;
    ticks(4);
    check_eq("pol2_no_err", 32'(pol_err), 0);
    mon_reset_n = 1'b0;
    ticks(3);
    mon_reset_n = 1'b1;
    ticks(4);
    check_eq("pol3_err", 32'(pol_err), 1);

    // Asynchronous monitor reset in the middle of a measurement.
    drive_clk(5, 5, 2);
    mon_clk = 1'b1;
    ticks(2);
    check_eq("pre_arst_pol_err", 32'(pol_err), 1);
    #3 reset = 1'b1;
    #1;
    check_all_zero("arst");
    tick();
    mon_clk = 1'b0;
    reset = 1'b0;
    pv_cnt = 0;
    tick();
    drive_clk(5, 5, 1);
    check_eq("post_arst_first_no_valid", 32'(pv_cnt), 0);
    drive_clk(5, 5, 1);
    check_eq("post_arst_valid_count", 32'(pv_cnt), 1);
    check_eq("post_arst_period", 32'(period), 10);
    check_eq("post_arst_pol_err", 32'(pol_err), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
